// File: rtl/e203_exu_fpu_wbck_buf_pkg.sv
// ---------------------------------------------------------------------------
// e203_exu_fpu_wbck_buf_pkg
//   Shared constants and types for the FPU misc-move writeback buffer.
//   - E203_FPU_WBCK_DW   : writeback data width
//   - E203_RFIDX_WIDTH   : destination register index width
//   - fpu_wbck_pay_t     : payload layout {rdfpu, rdidx, wdat}, MSB first
//   - wbck_cnt_t         : occupancy type for the 2-entry buffer
// ---------------------------------------------------------------------------
package e203_exu_fpu_wbck_buf_pkg;

    localparam int E203_FPU_WBCK_DW = 32;
    localparam int E203_RFIDX_WIDTH = 5;

    // Payload width for the default widths: rdfpu + rdidx + wdat.
    localparam int E203_FPU_WBCK_PW = 1 + E203_RFIDX_WIDTH + E203_FPU_WBCK_DW;

    // Packing order used everywhere the payload travels as a flat vector.
    typedef struct packed {
        logic                        rdfpu;
        logic [E203_RFIDX_WIDTH-1:0] rdidx;
        logic [E203_FPU_WBCK_DW-1:0] wdat;
    } fpu_wbck_pay_t;

    typedef logic [1:0] wbck_cnt_t;

    localparam wbck_cnt_t WBCK_CNT_EMPTY = 2'd0;
    localparam wbck_cnt_t WBCK_CNT_FULL  = 2'd2;

endpackage

// File: rtl/e203_exu_fpu_wbck_fifo2.sv
// ---------------------------------------------------------------------------
// e203_exu_fpu_wbck_fifo2
//   Generic two-entry payload FIFO with synchronous flush.
//   Ports:
//     clk, rst      : clock, asynchronous active-high reset
//     flush         : clear occupancy and pointers at the next edge
//     push, wdat    : write wdat into the tail entry (ignored when full)
//     pop           : retire the head entry (ignored when empty)
//     rdat          : head entry payload (registered storage, mux only)
//     cnt           : occupancy 0..2
//   Payload storage is intentionally not reset; it is only observed while
//   cnt is non-zero.
// ---------------------------------------------------------------------------
module e203_exu_fpu_wbck_fifo2
    import e203_exu_fpu_wbck_buf_pkg::*;
#(
    parameter int W = E203_FPU_WBCK_PW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdat,
    output logic [W-1:0]  rdat,
    output wbck_cnt_t     cnt
);

    logic [W-1:0] mem [2];
    logic         wptr;
    logic         rptr;
    wbck_cnt_t    cnt_q;
    logic         do_push;
    logic         do_pop;

    // Local guards keep the counter within 0..2 even if a caller misbehaves.
    assign do_push = push && (cnt_q != WBCK_CNT_FULL);
    assign do_pop  = pop  && (cnt_q != WBCK_CNT_EMPTY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= WBCK_CNT_EMPTY;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
        end else if (flush) begin
            // Flush wins over any handshake in the same cycle.
            cnt_q <= WBCK_CNT_EMPTY;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
        end else begin
            if (do_push) begin
                wptr <= ~wptr;
            end
            if (do_pop) begin
                rptr <= ~rptr;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wptr] <= wdat;
        end
    end

    assign rdat = mem[rptr];
    assign cnt  = cnt_q;

endmodule

// File: rtl/e203_exu_fpu_wbck_buf.sv
// ---------------------------------------------------------------------------
// e203_exu_fpu_wbck_buf
//   Two-entry writeback buffer between the FPU misc-move unit and the core
//   writeback arbiter. Breaks the valid/ready combinational path: i_ready
//   depends only on internal flops and flush, o_valid only on flops.
//   Ports:
//     clk, rst                    : clock, asynchronous active-high reset
//     flush                       : drop all buffered beats and the incoming
//                                   beat this cycle
//     fmis_wbck_i_valid/ready     : upstream handshake
//     fmis_wbck_i_wdat/rdidx/rdfpu: upstream payload
//     fmis_wbck_o_valid/ready     : downstream handshake toward the arbiter
//     fmis_wbck_o_wdat/rdidx/rdfpu: head payload
//     fmis_wbck_cnt               : occupancy 0..2
//
//   Handshake: a beat transfers on a clock edge where valid && ready are both
//   high; a source holding valid must keep its payload stable until the
//   transfer, and ready never depends combinationally on the peer's valid.
//   DEPTH is fixed at 2.
// ---------------------------------------------------------------------------
module e203_exu_fpu_wbck_buf
    import e203_exu_fpu_wbck_buf_pkg::*;
#(
    parameter int DW    = E203_FPU_WBCK_DW,
    parameter int RDW   = E203_RFIDX_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           fmis_wbck_i_valid,
    output logic           fmis_wbck_i_ready,
    input  logic [DW-1:0]  fmis_wbck_i_wdat,
    input  logic [RDW-1:0] fmis_wbck_i_rdidx,
    input  logic           fmis_wbck_i_rdfpu,
    output logic           fmis_wbck_o_valid,
    input  logic           fmis_wbck_o_ready,
    output logic [DW-1:0]  fmis_wbck_o_wdat,
    output logic [RDW-1:0] fmis_wbck_o_rdidx,
    output logic           fmis_wbck_o_rdfpu,
    output logic [1:0]     fmis_wbck_cnt
);

    localparam int PW = 1 + RDW + DW;

    logic [PW-1:0] in_pay;
    logic [PW-1:0] out_pay;
    logic          push;
    logic          pop;
    wbck_cnt_t     cnt;

    // Full blocks input even if the head pops this cycle: this keeps i_ready
    // free of any path from o_ready.
    assign fmis_wbck_i_ready = (cnt != 2'(DEPTH)) && !flush;
    assign fmis_wbck_o_valid = (cnt != WBCK_CNT_EMPTY);

    assign push = fmis_wbck_i_valid && fmis_wbck_i_ready;
    assign pop  = fmis_wbck_o_valid && fmis_wbck_o_ready;

    assign in_pay = {fmis_wbck_i_rdfpu, fmis_wbck_i_rdidx, fmis_wbck_i_wdat};

    e203_exu_fpu_wbck_fifo2 #(
        .W (PW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdat  (in_pay),
        .rdat  (out_pay),
        .cnt   (cnt)
    );

    assign fmis_wbck_o_rdfpu = out_pay[PW-1];
    assign fmis_wbck_o_rdidx = out_pay[DW +: RDW];
    assign fmis_wbck_o_wdat  = out_pay[DW-1:0];
    assign fmis_wbck_cnt     = cnt;

`ifndef SYNTHESIS
    a_cnt_range: assert property (@(posedge clk) disable iff (rst)
        cnt <= WBCK_CNT_FULL);

    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
        !(push && (cnt == WBCK_CNT_FULL)));

    // A stalled head must hold still unless a flush discards it.
    a_out_stable: assert property (@(posedge clk) disable iff (rst)
        (fmis_wbck_o_valid && !fmis_wbck_o_ready && !flush) |=>
        (fmis_wbck_o_valid && $stable(out_pay)));
`endif

endmodule

// File: tb/tb_e203_exu_fpu_wbck_buf.sv
module tb_e203_exu_fpu_wbck_buf;

    localparam int DW = 32;
    localparam int RDW = 5;
    localparam int PW = 1 + RDW + DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic           flush;
    logic           i_valid;
    logic           i_ready;
    logic [DW-1:0]  i_wdat;
    logic [RDW-1:0] i_rdidx;
    logic           i_rdfpu;
    logic           o_valid;
    logic           o_ready;
    logic [DW-1:0]  o_wdat;
    logic [RDW-1:0] o_rdidx;
    logic           o_rdfpu;
    logic [1:0]     cnt;

    e203_exu_fpu_wbck_buf dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .fmis_wbck_i_valid (i_valid),
        .fmis_wbck_i_ready (i_ready),
        .fmis_wbck_i_wdat  (i_wdat),
        .fmis_wbck_i_rdidx (i_rdidx),
        .fmis_wbck_i_rdfpu (i_rdfpu),
        .fmis_wbck_o_valid (o_valid),
        .fmis_wbck_o_ready (o_ready),
        .fmis_wbck_o_wdat  (o_wdat),
        .fmis_wbck_o_rdidx (o_rdidx),
        .fmis_wbck_o_rdfpu (o_rdfpu),
        .fmis_wbck_cnt     (cnt)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- scoreboard ----------------
    // Expected buffer contents, head first, as {rdfpu, rdidx, wdat}.
    logic [PW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [RDW-1:0] idx,
                         input logic fpu, input logic ordy, input logic fl);
        i_valid = v;
        i_wdat  = d;
        i_rdidx = idx;
        i_rdfpu = fpu;
        o_ready = ordy;
        flush   = fl;
    endtask

    // One cycle checked against the FIFO reference model.
    task automatic model_cycle(input logic v, input logic [DW-1:0] d, input logic [RDW-1:0] idx,
                               input logic fpu, input logic ordy, input logic fl);
        logic exp_ir;
        logic exp_ov;
        drive(v, d, idx, fpu, ordy, fl);
        @(negedge clk);
        exp_ir = (exp_q.size() < 2) && !fl;
        exp_ov = (exp_q.size() != 0);
        check("m_i_ready", 64'(i_ready), 64'(exp_ir));
        check("m_o_valid", 64'(o_valid), 64'(exp_ov));
        check("m_cnt", 64'(cnt), 64'(exp_q.size()));
        if (exp_ov) check("m_head", 64'({o_rdfpu, o_rdidx, o_wdat}), 64'(exp_q[0]));
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
        end else begin
            if (exp_ov && ordy) void'(exp_q.pop_front());
            if (v && exp_ir) exp_q.push_back({fpu, idx, d});
        end
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic           v;
        logic [DW-1:0]  d;
        logic [RDW-1:0] idx;
        logic           fpu;
        logic           ordy;
        logic           fl;
        logic           e_ir;
        logic           e_ov;
        logic [DW-1:0]  e_d;
        logic [RDW-1:0] e_idx;
        logic           e_fpu;
        logic [1:0]     e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [DW-1:0] d, logic [RDW-1:0] idx, logic fpu,
                                logic ordy, logic fl, logic e_ir, logic e_ov,
                                logic [DW-1:0] e_d, logic [RDW-1:0] e_idx, logic e_fpu,
                                logic [1:0] e_cnt);
        vec_t r;
        r.v = v; r.d = d; r.idx = idx; r.fpu = fpu; r.ordy = ordy; r.fl = fl;
        r.e_ir = e_ir; r.e_ov = e_ov; r.e_d = e_d; r.e_idx = e_idx; r.e_fpu = e_fpu;
        r.e_cnt = e_cnt;
        return r;
    endfunction

    task automatic build_table();
        //                v  d             idx fpu ordy fl  ir ov e_d           eidx efpu cnt
        // single beat
        tbl.push_back(mk(1, 32'h3F80_0000, 5, 0, 1, 0,   1, 0, 0,            0, 0, 0));
        tbl.push_back(mk(0, 0,             0, 0, 1, 0,   1, 1, 32'h3F80_0000, 5, 0, 1));
        tbl.push_back(mk(0, 0,             0, 0, 1, 0,   1, 0, 0,            0, 0, 0));
        // back-pressure fill, then drain in order
        tbl.push_back(mk(1, 32'h11,        1, 1, 0, 0,   1, 0, 0,            0, 0, 0));
        tbl.push_back(mk(1, 32'h22,        2, 0, 0, 0,   1, 1, 32'h11,       1, 1, 1));
        tbl.push_back(mk(1, 32'h33,        3, 0, 0, 0,   0, 1, 32'h11,       1, 1, 2));
        tbl.push_back(mk(0, 0,             0, 0, 1, 0,   0, 1, 32'h11,       1, 1, 2));
        tbl.push_back(mk(0, 0,             0, 0, 1, 0,   1, 1, 32'h22,       2, 0, 1));
        tbl.push_back(mk(0, 0,             0, 0, 1, 0,   1, 0, 0,            0, 0, 0));
        // streaming 0..7 with o_ready held: head lags input by one cycle
        for (int i = 0; i < 8; i++) begin
            if (i == 0)
                tbl.push_back(mk(1, 32'(i), 5'(i), 1'(i % 2), 1, 0, 1, 0, 0, 0, 0, 0));
            else
                tbl.push_back(mk(1, 32'(i), 5'(i), 1'(i % 2), 1, 0, 1, 1,
                                 32'(i - 1), 5'(i - 1), 1'((i - 1) % 2), 1));
        end
        tbl.push_back(mk(0, 0,             0, 0, 1, 0,   1, 1, 32'h7,        7, 1, 1));
        tbl.push_back(mk(0, 0,             0, 0, 1, 0,   1, 0, 0,            0, 0, 0));
        // simultaneous push/pop at cnt=1
        tbl.push_back(mk(1, 32'hAA,        3, 1, 0, 0,   1, 0, 0,            0, 0, 0));
        tbl.push_back(mk(1, 32'hBB,        4, 0, 1, 0,   1, 1, 32'hAA,       3, 1, 1));
        tbl.push_back(mk(0, 0,             0, 0, 0, 0,   1, 1, 32'hBB,       4, 0, 1));
        tbl.push_back(mk(0, 0,             0, 0, 1, 0,   1, 1, 32'hBB,       4, 0, 1));
        tbl.push_back(mk(0, 0,             0, 0, 1, 0,   1, 0, 0,            0, 0, 0));
        // flush at cnt=2 with an incoming beat 0xCC
        tbl.push_back(mk(1, 32'h44,        1, 0, 0, 0,   1, 0, 0,            0, 0, 0));
        tbl.push_back(mk(1, 32'h55,        2, 1, 0, 0,   1, 1, 32'h44,       1, 0, 1));
        tbl.push_back(mk(1, 32'hCC,        6, 1, 0, 1,   0, 1, 32'h44,       1, 0, 2));
        tbl.push_back(mk(0, 0,             0, 0, 1, 0,   1, 0, 0,            0, 0, 0));
        tbl.push_back(mk(0, 0,             0, 0, 1, 0,   1, 0, 0,            0, 0, 0));
    endtask

    // ---------------- main test ----------------
    initial begin
        drive(0, 0, 0, 0, 0, 0);
        build_table();

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_o_valid", 64'(o_valid), 64'(0));
        check("rst_i_ready", 64'(i_ready), 64'(1));
        check("rst_cnt", 64'(cnt), 64'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // directed table
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].idx, tbl[i].fpu, tbl[i].ordy, tbl[i].fl);
            @(negedge clk);
            check($sformatf("t%0d_i_ready", i), 64'(i_ready), 64'(tbl[i].e_ir));
            check($sformatf("t%0d_o_valid", i), 64'(o_valid), 64'(tbl[i].e_ov));
            check($sformatf("t%0d_cnt", i), 64'(cnt), 64'(tbl[i].e_cnt));
            if (tbl[i].e_ov) begin
                check($sformatf("t%0d_wdat", i), 64'(o_wdat), 64'(tbl[i].e_d));
                check($sformatf("t%0d_rdidx", i), 64'(o_rdidx), 64'(tbl[i].e_idx));
                check($sformatf("t%0d_rdfpu", i), 64'(o_rdfpu), 64'(tbl[i].e_fpu));
            end
            @(posedge clk);
            #1;
        end

        // async reset mid-stream with two beats buffered
        exp_q.delete();
        model_cycle(1, 32'hA1, 9, 1, 0, 0);
        model_cycle(1, 32'hA2, 10, 0, 0, 0);
        drive(1, 32'hA3, 11, 0, 0, 0);
        @(negedge clk);
        check("pre_rst_cnt", 64'(cnt), 64'(2));
        #2;
        rst = 1'b1;
        #1;
        check("async_o_valid", 64'(o_valid), 64'(0));
        check("async_cnt", 64'(cnt), 64'(0));
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("post_rst_i_ready", 64'(i_ready), 64'(1));
        check("post_rst_o_valid", 64'(o_valid), 64'(0));
        @(posedge clk);
        #1;

        // randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            model_cycle($urandom_range(0, 99) < 70, $urandom(), 5'($urandom_range(0, 31)),
                        1'($urandom_range(0, 1)), $urandom_range(0, 99) < 55,
                        $urandom_range(0, 99) < 4);
        end
        // drain
        for (int n = 0; n < 4; n++) model_cycle(0, 0, 0, 0, 1, 0);

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
